decoder_nto2n_sweep: RTL

//  Parametrised, registered N-to-2^N one-hot decoder with a valid/ready input handshake.

---
 rtl/decoder_nto2n_sweep_if.sv | 29 ++
 rtl/decoder_nto2n_sweep.sv | 112 +++++++++++
 2 files changed

// File: rtl/decoder_nto2n_sweep_if.sv
// Bundle of direct-decode handshake, sweep control and decoded outputs for decoder_nto2n_sweep.
// master drives the code/handshake/start side; slave is the decoder itself.
interface decoder_nto2n_sweep_if #(
  parameter int N = 4
);
  localparam int M = 1 << N;

  logic         en;
  logic [N-1:0] i;
  logic         in_valid;
  logic         in_ready;
  logic         sweep_start;
  logic [M-1:0] d;
  logic         out_valid;
  logic [N-1:0] code;
  logic         sweep_busy;
  logic         sweep_done;
  logic [1:0]   dbg_state;

  modport master (
    output en, i, in_valid, sweep_start,
    input  in_ready, d, out_valid, code, sweep_busy, sweep_done, dbg_state
  );

  modport slave (
    input  en, i, in_valid, sweep_start,
    output in_ready, d, out_valid, code, sweep_busy, sweep_done, dbg_state
  );
endinterface

// File: rtl/decoder_nto2n_sweep.sv
// Registered N-to-2^N one-hot decoder with valid/ready input and a built-in code sweep engine.
// Optional macro DEC_ACTIVE_LOW_EN makes d active-low (all ones when blank).
module decoder_nto2n_sweep #(
  parameter int N     = 4,
  parameter int DWELL = 10
) (
  input logic               clk,
  input logic               rst,
  decoder_nto2n_sweep_if.slave bus
);
  localparam int M  = 1 << N;
  localparam int DW = $clog2(DWELL + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [N-1:0]  CODE_LAST  = '1;

`ifdef DEC_ACTIVE_LOW_EN
  localparam logic [M-1:0] BLANK = '1;
`else
  localparam logic [M-1:0] BLANK = '0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        r_state;
  logic [M-1:0]  r_d;
  logic [N-1:0]  r_code;
  logic [DW-1:0] r_dwell;
  logic          r_out_valid;
  logic          r_sweep_done;
  logic          w_in_ready;

  function automatic logic [M-1:0] drive_val(input logic [N-1:0] c);
    logic [M-1:0] oh;
    oh = {{(M-1){1'b0}}, 1'b1} << c;
`ifdef DEC_ACTIVE_LOW_EN
    return ~oh;
`else
    return oh;
`endif
  endfunction

  // Handshake: an input transfer happens on a rising edge where in_valid & in_ready;
  // in_ready is combinational and only high in IDLE with en high and no sweep_start.
  assign w_in_ready = (r_state == S_IDLE) && bus.en && !bus.sweep_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_d          <= BLANK;
      r_code       <= '0;
      r_dwell      <= '0;
      r_out_valid  <= 1'b0;
      r_sweep_done <= 1'b0;
    end else begin
      r_out_valid  <= 1'b0;
      r_sweep_done <= 1'b0;
      if (r_state == S_DONE) begin
        // DONE lasts exactly one cycle whatever en does, so sweep_done stays a pulse.
        r_state <= S_IDLE;
        r_d     <= BLANK;
      end else if (!bus.en) begin
        r_d <= BLANK;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (bus.sweep_start) begin
              r_state <= S_SWEEP;
              r_code  <= '0;
              r_dwell <= '0;
              r_d     <= drive_val('0);
            end else if (bus.in_valid) begin
              r_code      <= bus.i;
              r_d         <= drive_val(bus.i);
              r_out_valid <= 1'b1;
            end
          end
          S_SWEEP: begin
            if (r_dwell == DWELL_LAST) begin
              r_dwell <= '0;
              if (r_code == CODE_LAST) begin
                r_state      <= S_DONE;
                r_code       <= '0;
                r_d          <= BLANK;
                r_sweep_done <= 1'b1;
              end else begin
                r_code <= r_code + N'(1);
                r_d    <= drive_val(r_code + N'(1));
              end
            end else begin
              // Re-driving the current code also restores d after an en-low blank.
              r_dwell <= r_dwell + DW'(1);
              r_d     <= drive_val(r_code);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.d          = r_d;
  assign bus.out_valid  = r_out_valid;
  assign bus.code       = r_code;
  assign bus.sweep_busy = (r_state == S_SWEEP);
  assign bus.sweep_done = r_sweep_done;
  assign bus.dbg_state  = r_state;
endmodule
